// File: rtl/rsa_stream_host_if.sv
// Handshake bundle between the RSA stream host and its job/operand/accelerator/result peers.
interface rsa_stream_host_if #(
  parameter int FDW = 32,
  parameter int K   = 128
);
  logic           clr;
  logic           job_go;
  logic           job_busy;
  logic           job_done;
  logic           op_vld;
  logic           op_rdy;
  logic [K-1:0]   op_data;
  logic           acc_start;
  logic           acc_rdy;
  logic           acc_vld;
  logic [FDW-1:0] acc_dout;
  logic           res_vld;
  logic           res_rdy;
  logic [FDW-1:0] res_din;
  logic           out_vld;
  logic           out_rdy;
  logic [K-1:0]   out_data;
  logic           out_last;
  logic           err;

  modport slave (
    input  clr, job_go, op_vld, op_data, acc_rdy, res_vld, res_din, out_rdy,
    output job_busy, job_done, op_rdy, acc_start, acc_vld, acc_dout,
           res_rdy, out_vld, out_data, out_last, err
  );

  modport master (
    output clr, job_go, op_vld, op_data, acc_rdy, res_vld, res_din, out_rdy,
    input  job_busy, job_done, op_rdy, acc_start, acc_vld, acc_dout,
           res_rdy, out_vld, out_data, out_last, err
  );
endinterface

// File: rtl/rsa_stream_host.sv
// Streams N K-bit operands to an FDW-wide accelerator and reassembles N K-bit results.
// Optional RECV watchdog: define RSA_HOST_TIMEOUT_EN.
module rsa_stream_host #(
  parameter int FDW = 32,
  parameter int K   = 128,
  parameter int N   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rsa_stream_host_if.slave     bus
);
  localparam int W   = K / FDW;
  localparam int WCW = (W > 1) ? $clog2(W) : 1;
  localparam int OCW = $clog2(N + 1);
  localparam logic [WCW-1:0] WLAST = WCW'(W - 1);
  localparam logic [OCW-1:0] OLAST = OCW'(N - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;

  state_t          r_state, w_next;
  logic [K-1:0]    r_tx, r_rx, w_rx_nxt;
  logic            r_tx_full, r_out_vld, r_out_last, r_start, r_done;
  logic [WCW-1:0]  r_twc, r_rwc;
  logic [OCW-1:0]  r_opc, r_resc;
  logic            w_op_hs, w_acc_hs, w_res_hs, w_out_hs;
  logic            w_tx_last, w_rx_last, w_to, w_go;

  assign w_op_hs   = bus.op_vld  & bus.op_rdy;
  assign w_acc_hs  = bus.acc_vld & bus.acc_rdy;
  assign w_res_hs  = bus.res_vld & bus.res_rdy;
  assign w_out_hs  = bus.out_vld & bus.out_rdy;
  assign w_tx_last = w_acc_hs && (r_twc == WLAST);
  assign w_rx_last = w_res_hs && (r_rwc == WLAST);
  assign w_go      = (r_state == IDLE) && bus.job_go;

  assign bus.op_rdy    = (r_state == SEND) && !r_tx_full;
  assign bus.acc_vld   = (r_state == SEND) && r_tx_full;
  assign bus.acc_dout  = r_tx[FDW-1:0];
  assign bus.res_rdy   = (r_state == RECV) && !r_out_vld;
  assign bus.out_vld   = r_out_vld;
  assign bus.out_data  = r_rx;
  assign bus.out_last  = r_out_last;
  assign bus.acc_start = r_start;
  assign bus.job_done  = r_done;
  assign bus.job_busy  = (r_state != IDLE);

  // New words enter at the MSB end so the first word lands least significant.
  generate
    if (W > 1) begin : g_rx_shift
      assign w_rx_nxt = {bus.res_din, r_rx[K-1:FDW]};
    end else begin : g_rx_word
      assign w_rx_nxt = bus.res_din;
    end
  endgenerate

`ifdef RSA_HOST_TIMEOUT_EN
  logic [15:0] r_wd;
  logic        r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else if (bus.clr) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_to;
      if (r_state != RECV || w_res_hs || w_out_hs) r_wd <= '0;
      else                                          r_wd <= r_wd + 16'd1;
    end
  end

  // Fires on the 65535th consecutive cycle without any result-side progress.
  assign w_to    = (r_state == RECV) && !w_res_hs && !w_out_hs && (r_wd == 16'hFFFE);
  assign bus.err = r_err;
`else
  assign w_to    = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_state <= IDLE;
    else if (bus.clr) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.job_go) w_next = SEND;
      SEND:    if (w_tx_last && (r_opc == OLAST)) w_next = RECV;
      RECV: begin
        if (w_out_hs && r_out_last) w_next = IDLE;
        else if (w_to)              w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_tx_full  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_twc      <= '0;
      r_rwc      <= '0;
      r_opc      <= '0;
      r_resc     <= '0;
    end else if (bus.clr) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_tx_full  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_twc      <= '0;
      r_rwc      <= '0;
      r_opc      <= '0;
      r_resc     <= '0;
    end else begin
      r_start <= w_go;
      r_done  <= (r_state == RECV) && w_out_hs && r_out_last;

      if (w_go) begin
        r_tx_full <= 1'b0;
        r_twc     <= '0;
        r_rwc     <= '0;
        r_opc     <= '0;
        r_resc    <= '0;
      end

      if (w_op_hs) begin
        r_tx      <= bus.op_data;
        r_tx_full <= 1'b1;
      end else if (w_acc_hs) begin
        r_tx  <= r_tx >> FDW;
        r_twc <= w_tx_last ? '0 : r_twc + 1'b1;
        if (w_tx_last) begin
          r_tx_full <= 1'b0;
          r_opc     <= r_opc + 1'b1;
        end
      end

      if (w_res_hs) begin
        r_rx  <= w_rx_nxt;
        r_rwc <= w_rx_last ? '0 : r_rwc + 1'b1;
        if (w_rx_last) begin
          r_out_vld  <= 1'b1;
          r_out_last <= (r_resc == OLAST);
        end
      end

      if (w_out_hs || w_to) begin
        r_out_vld  <= 1'b0;
        r_out_last <= 1'b0;
        if (w_out_hs) r_resc <= r_resc + 1'b1;
      end
    end
  end
endmodule
